negacyclic_pp_unit: RTL and testbench
=====================================

# negacyclic_pp_unit

Parametrised pre/post-processing unit for negacyclic polynomial multiplication around the pipelined radix-2 NTT core. It moves the twist (×ψ^i), pointwise product (A·B), and untwist-and-scale (×N⁻¹·ψ⁻ⁱ) steps into hardware. Whole N-coefficient vectors move on a valid/ready handshake through a 2-stage modular-multiply pipeline. After reset, an init FSM builds the ψ-power tables sequentially, so no tables are hand-computed per parameter set.

## Interface
- W, 32: coefficient width; all inputs are < Modulus_Q.
- N, 8: coefficients per vector; power of two, ≥ 2.
- Modulus_Q, 241: prime modulus; Modulus_Q < 2^W.
- PSI, 111: primitive 2N-th root of unity mod Q.
- PSI_INV, 76: PSI⁻¹ mod Q.
- N_INV, 211: N⁻¹ mod Q.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  unit accepts a vector this cycle.
- mode_in  in  2  0 TWIST, 1 POINTWISE, 2 UNTWIST, 3 PASS.
- a_in  in  W×[0:N-1]  operand A.
- b_in  in  W×[0:N-1]  operand B; used only in POINTWISE.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- mode_out  out  2  mode_in travelling with the vector.
- c_out  out  W×[0:N-1]  result; every element is < Q.
- init_done  out  1  tables built; unit operational.

## Operation
- FSM states:
  - S_INIT: entered from reset. Counter k runs 0..N-1, writing one table entry per cycle.
    - tw[0]=1, tw[k]=tw[k-1]·PSI mod Q.
    - ut[0]=U0, ut[k]=ut[k-1]·PSI_INV mod Q.
  - S_RUN: entered after k=N-1. init_done=1. The FSM stays in S_RUN until reset.
- Per-element function, applied to all N lanes in parallel:
  - TWIST: c[i]=a[i]·tw[i] mod Q.
  - POINTWISE: c[i]=a[i]·b[i] mod Q.
  - UNTWIST: c[i]=a[i]·ut[i] mod Q.
  - PASS: c[i]=a[i]·1 mod Q, using the same pipeline path.
- Arithmetic: the product is a full 2W bits with no truncation before the reduction; the reduced result is W bits.
- Pipeline:
  - Stage 1 registers the selected multiplier operand and the 2W-bit product.
  - Stage 2 registers the mod-Q result, the mode, and valid.
- Handshake:
  - Advance enable: en = !out_valid || out_ready.
  - in_ready = init_done && en.
  - A vector transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
  - While stalled (en=0), both stages hold and c_out/mode_out stay stable.
- Boundaries:
  - in_valid during S_INIT is ignored (in_ready=0).
  - Input changes while in_ready=0 have no effect.
  - Simultaneous accept and drain in the same cycle gives full throughput with no bubble.
  - Reset asserted mid-operation drops all in-flight vectors. After release the unit runs the full re-init.
  - a_in ≥ Q is illegal and the output is undefined; the bench must not drive it.

## Timing
- Reset values: in_ready=0, out_valid=0, init_done=0, mode_out=0, c_out all 0. Tables are cleared and k=0.
- init_done rises N cycles after the first rising clk edge with reset high (8 cycles at the default N).
- Latency: a vector accepted at edge t gives out_valid=1 after edge t+2, provided there is no stall.
- Throughput: one vector per cycle. Capacity is 2 vectors in flight.
- With out_ready=0, at most 2 vectors are accepted before in_ready drops.

## Configuration
- NEGA_PP_NINV_FOLD_EN:
  - Defined: U0=N_INV, so ut[i]=N⁻¹·ψ⁻ⁱ and UNTWIST completes scaling and untwist in one pass.
  - Undefined: U0=1, so ut[i]=ψ⁻ⁱ and the caller applies N⁻¹ separately (for example with PASS replaced externally).
- Init cycle count, latency, and the handshake are identical in both builds.

## Structure
- Shared package negacyclic_pkg holds:
  - the mode enum (MODE_TWIST, MODE_POINTWISE, MODE_UNTWIST, MODE_PASS);
  - the FSM state enum;
  - the default Q/PSI/PSI_INV/N_INV localparams shared with the NTT bench.
- One sub-module, mod_mul_pipe: a 2-stage W×W→2W multiply and mod-Q reduction with an enable. It is instantiated N times in the datapath and once for the init FSM. The init instance ignores stall, because the datapath is idle during S_INIT.

## Test plan
All scenarios use the default parameters and the fold build unless noted.
- Reset and init: hold reset low 3 cycles, then release. Outputs must be 0, and init_done must rise exactly 8 cycles after release.
- TWIST on a_in = all 1s: c_out = [1,111,30,197,177,126,8,165], mode_out=0, out_valid 2 cycles after accept.
- POINTWISE on a = b = all 240: c_out = all 1. With a=[1..8] and b = all 0, c_out = all 0.
- Round trip: TWIST of [8,0,0,0,0,0,0,0] is fed into UNTWIST.
  - Fold build: [1,0,…].
  - Non-fold build: [8,0,…].
  - UNTWIST of all 1s in the fold build gives c[0]=211 and c[1]=130.
- Back-pressure: issue 3 back-to-back TWIST vectors with out_ready=0 for 4 cycles. in_ready must drop after 2 accepts, c_out must stay stable, and all 3 results must arrive in order with no loss or duplication.
- Reset mid-stream: drive reset low with 2 vectors in flight. out_valid must go to 0 immediately, and after release there must be no stale output and the 8-cycle re-init must be repeated.

Source files
------------

// File: rtl/negacyclic_pkg.sv
// Shared types and default parameter set for the negacyclic pre/post-processing unit
// and the NTT bench around it.
package negacyclic_pkg;

  typedef enum logic [1:0] {
    MODE_TWIST     = 2'd0,
    MODE_POINTWISE = 2'd1,
    MODE_UNTWIST   = 2'd2,
    MODE_PASS      = 2'd3
  } mode_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int          DEF_W       = 32;
  localparam int          DEF_N       = 8;
  localparam logic [63:0] DEF_Q       = 64'd241;
  localparam logic [63:0] DEF_PSI     = 64'd111;
  localparam logic [63:0] DEF_PSI_INV = 64'd76;
  localparam logic [63:0] DEF_N_INV   = 64'd211;

  // Elaboration-time helper for deriving table seeds and strides.
  function automatic logic [63:0] mul_mod(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] q);
    return (a * b) % q;
  endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Two-stage modular multiplier: stage 1 holds the full 2W-bit product, stage 2 the
// W-bit residue mod Q. LANES independent lanes share the per-stage load enables.
module mod_mul_pipe
  import negacyclic_pkg::*;
#(
  parameter int          W     = DEF_W,
  parameter int          LANES = 1,
  parameter logic [63:0] Q     = DEF_Q
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en1,
  input  logic               en2,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic [LANES*W-1:0] res
);

  localparam int            W2   = 2 * W;
  localparam logic [W2-1:0] Q_2W = W2'(Q);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W2-1:0] prod_d, prod_q;
    logic [W-1:0]  res_d, res_q;

    always_comb begin
      prod_d = prod_q;
      res_d  = res_q;
      if (en1) prod_d = {{W{1'b0}}, a[gi*W +: W]} * {{W{1'b0}}, b[gi*W +: W]};
      if (en2) res_d = W'(prod_q % Q_2W);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
        res_q  <= '0;
      end else begin
        prod_q <= prod_d;
        res_q  <= res_d;
      end
    end

    assign res[gi*W +: W] = res_q;
  end

endmodule

// File: rtl/negacyclic_pp_unit.sv
// Twist / pointwise / untwist pre- and post-processing for negacyclic NTT multiply.
// Define NEGA_PP_NINV_FOLD_EN to fold N^-1 into the untwist table.
module negacyclic_pp_unit
  import negacyclic_pkg::*;
#(
  parameter int          W         = DEF_W,
  parameter int          N         = DEF_N,
  parameter logic [63:0] Modulus_Q = DEF_Q,
  parameter logic [63:0] PSI       = DEF_PSI,
  parameter logic [63:0] PSI_INV   = DEF_PSI_INV,
  parameter logic [63:0] N_INV     = DEF_N_INV
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode_in,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     mode_out,
  output logic [N*W-1:0] c_out,
  output logic           init_done
);

  localparam int KW = $clog2(N);
`ifdef NEGA_PP_NINV_FOLD_EN
  localparam logic [63:0] U0 = N_INV;
`else
  localparam logic [63:0] U0 = 64'd1;
`endif
  // The init pipe has two cycles of latency, so each table is built as two
  // interleaved chains stepping by the square of the root.
  localparam logic [W-1:0] TW_SEED0 = W'(64'd1);
  localparam logic [W-1:0] TW_SEED1 = W'(PSI % Modulus_Q);
  localparam logic [W-1:0] UT_SEED0 = W'(U0 % Modulus_Q);
  localparam logic [W-1:0] UT_SEED1 = W'(mul_mod(U0, PSI_INV, Modulus_Q));
  localparam logic [W-1:0] TW_STEP  = W'(mul_mod(PSI, PSI, Modulus_Q));
  localparam logic [W-1:0] UT_STEP  = W'(mul_mod(PSI_INV, PSI_INV, Modulus_Q));

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  tw_q [N];
  logic [W-1:0]  tw_d [N];
  logic [W-1:0]  ut_q [N];
  logic [W-1:0]  ut_d [N];
  logic [W-1:0]  tw_wr, ut_wr;
  logic [2*W-1:0] init_res;
  logic          init_en;

  assign init_en = (state_q == S_INIT);

  mod_mul_pipe #(.W(W), .LANES(2), .Q(Modulus_Q)) u_init_mul (
    .clk   (clk),
    .reset (reset),
    .en1   (init_en),
    .en2   (init_en),
    .a     ({ut_wr, tw_wr}),
    .b     ({UT_STEP, TW_STEP}),
    .res   (init_res)
  );

  always_comb begin
    tw_wr = init_res[0 +: W];
    ut_wr = init_res[W +: W];
    if (k_q == '0) begin
      tw_wr = TW_SEED0;
      ut_wr = UT_SEED0;
    end else if (k_q == KW'(1)) begin
      tw_wr = TW_SEED1;
      ut_wr = UT_SEED1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tw_d    = tw_q;
    ut_d    = ut_q;
    if (state_q == S_INIT) begin
      tw_d[k_q] = tw_wr;
      ut_d[k_q] = ut_wr;
      if (k_q == KW'(N - 1)) state_d = S_RUN;
      else k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      k_q     <= '0;
      for (int i = 0; i < N; i++) begin
        tw_q[i] <= '0;
        ut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tw_q    <= tw_d;
      ut_q    <= ut_d;
    end
  end

  assign init_done = (state_q == S_RUN);

  logic en, accept;
  logic v1_q, v1_d, out_valid_q, out_valid_d;
  logic [1:0] mode1_q, mode1_d, mode_out_q, mode_out_d;
  logic [N*W-1:0] op_vec;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = init_done && en;
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_opsel
    logic [W-1:0] op_sel;
    always_comb begin
      op_sel = W'(64'd1);
      case (mode_in)
        MODE_TWIST:     op_sel = tw_q[gi];
        MODE_POINTWISE: op_sel = b_in[gi*W +: W];
        MODE_UNTWIST:   op_sel = ut_q[gi];
        default:        op_sel = W'(64'd1);
      endcase
    end
    assign op_vec[gi*W +: W] = op_sel;
  end

  // Stage registers only load when a real vector moves in, so outputs stay put
  // across bubbles and stalls.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mod_mul_pipe #(.W(W), .LANES(1), .Q(Modulus_Q)) u_mul (
      .clk   (clk),
      .reset (reset),
      .en1   (accept),
      .en2   (en && v1_q),
      .a     (a_in[gi*W +: W]),
      .b     (op_vec[gi*W +: W]),
      .res   (c_out[gi*W +: W])
    );
  end

  always_comb begin
    v1_d        = v1_q;
    mode1_d     = mode1_q;
    out_valid_d = out_valid_q;
    mode_out_d  = mode_out_q;
    if (en) begin
      v1_d        = accept;
      out_valid_d = v1_q;
      if (accept) mode1_d = mode_in;
      if (v1_q) mode_out_d = mode1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      mode1_q     <= 2'd0;
      out_valid_q <= 1'b0;
      mode_out_q  <= 2'd0;
    end else begin
      v1_q        <= v1_d;
      mode1_q     <= mode1_d;
      out_valid_q <= out_valid_d;
      mode_out_q  <= mode_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mode_out  = mode_out_q;

endmodule

// File: tb/tb_negacyclic_pp_unit.sv
// Randomised, scoreboarded bench for negacyclic_pp_unit with directed boundary cases.
module tb_negacyclic_pp_unit;
  import negacyclic_pkg::*;

  localparam int W  = DEF_W;
  localparam int N  = DEF_N;
  localparam int CW = N * W;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, out_valid, out_ready, init_done;
  logic [1:0]     mode_in, mode_out;
  logic [CW-1:0]  a_in, b_in, c_out;

  negacyclic_pp_unit #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode_in   (mode_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mode_out  (mode_out),
    .c_out     (c_out),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    m;
    logic [CW-1:0] c;
  } exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_out    = 0;
  exp_t          exp_q[$];
  logic [63:0]   tw_m [N];
  logic [63:0]   ut_m [N];
  logic          stall_prev = 1'b0;
  logic [CW-1:0] c_prev;
  logic [1:0]    m_prev;
  int unsigned   exp_tw [N] = '{1, 111, 30, 197, 177, 126, 8, 165};

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pow_mod(input logic [63:0] base, input int e);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < e; i++) r = (r * base) % DEF_Q;
    return r;
  endfunction

  function automatic logic [CW-1:0] model(input logic [1:0] m, input logic [CW-1:0] a,
                                          input logic [CW-1:0] b);
    logic [CW-1:0] r;
    logic [63:0]   x, y;
    r = '0;
    for (int i = 0; i < N; i++) begin
      x = 64'(a[i*W +: W]);
      case (m)
        2'd0:    y = tw_m[i];
        2'd1:    y = 64'(b[i*W +: W]);
        2'd2:    y = ut_m[i];
        default: y = 64'd1;
      endcase
      r[i*W +: W] = W'((x * y) % DEF_Q);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] splat(input int unsigned v);
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [CW-1:0] pack(input int unsigned e [N]);
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  function automatic logic [CW-1:0] rand_vec();
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(int'(DEF_Q) - 1));
    return r;
  endfunction

  // One clock cycle of stimulus with scoreboard bookkeeping; returns whether a vector was taken.
  task automatic run_cycle(input logic v, input logic [1:0] m, input logic [CW-1:0] a,
                           input logic [CW-1:0] b, input logic ordy, output logic acc);
    exp_t e;
    in_valid = v; mode_in = m; a_in = a; b_in = b; out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("stall_c_stable", c_out, c_prev);
      check("stall_mode_stable", 2'(mode_out), 2'(m_prev));
    end
    stall_prev = out_valid && !out_ready;
    c_prev = c_out;
    m_prev = mode_out;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        $display("txn out mode=%0d c=%h exp=%h", mode_out, c_out, e.c);
        check("sb_c", c_out, e.c);
        check("sb_mode", 2'(mode_out), 2'(e.m));
        n_out++;
      end
    end
    if (acc) begin
      e.m = m;
      e.c = model(m, a, b);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Single vector with a free-running sink; also measures accept-to-valid latency.
  task automatic xfer(input string tag, input logic [1:0] m, input logic [CW-1:0] a,
                      input logic [CW-1:0] b, output logic [CW-1:0] c, output logic [1:0] mo);
    int   lat;
    logic got;
    in_valid = 1'b1; mode_in = m; a_in = a; b_in = b; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0; c = '0; mo = 2'd0;
    for (int i = 1; i <= 6 && !got; i++) begin
      if (out_valid) begin
        got = 1'b1; lat = i; c = c_out; mo = mode_out;
      end else begin
        @(posedge clk); #1;
      end
    end
    $display("txn %s mode=%0d c=%h latency=%0d", tag, mo, c, lat);
    check({tag, "_latency"}, lat, 2);
  endtask

  task automatic wait_init(input string tag);
    in_valid = 1'b1; mode_in = 2'd0; a_in = splat(1); b_in = '0; out_ready = 1'b1;
    for (int e = 1; e <= N; e++) begin
      @(posedge clk); #1;
      check({tag, "_init_done"}, init_done, e == N);
      check({tag, "_in_ready"}, in_ready, e == N);
      check({tag, "_no_out"}, out_valid, 1'b0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c, r, e_vec;
    logic [1:0]    mo;
    logic          acc;
    int            idx, n_before;
    logic [CW-1:0] bp_vec [3];
    logic [63:0]   u0_m;

`ifdef NEGA_PP_NINV_FOLD_EN
    u0_m = DEF_N_INV;
`else
    u0_m = 64'd1;
`endif
    for (int i = 0; i < N; i++) begin
      tw_m[i] = pow_mod(DEF_PSI, i);
      ut_m[i] = (u0_m * pow_mod(DEF_PSI_INV, i)) % DEF_Q;
    end

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode_in = 2'd0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_mode_out", 2'(mode_out), 2'd0);
    check("rst_c_out", c_out, '0);
    reset = 1'b1;
    wait_init("init");

    xfer("twist_ones", MODE_TWIST, splat(1), '0, c, mo);
    check("twist_ones_c", c, pack(exp_tw));
    check("twist_ones_mode", 2'(mo), 2'd0);

    xfer("pw_240", MODE_POINTWISE, splat(240), splat(240), c, mo);
    check("pw_240_c", c, splat(1));
    check("pw_240_mode", 2'(mo), 2'd1);
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(i + 1);
    xfer("pw_zero", MODE_POINTWISE, r, '0, c, mo);
    check("pw_zero_c", c, '0);

    r = '0; r[W-1:0] = W'(8);
    xfer("rt_twist", MODE_TWIST, r, '0, c, mo);
    check("rt_twist_c", c, r);
    xfer("rt_untwist", MODE_UNTWIST, c, '0, c, mo);
    e_vec = '0;
`ifdef NEGA_PP_NINV_FOLD_EN
    e_vec[W-1:0] = W'(1);
`else
    e_vec[W-1:0] = W'(8);
`endif
    check("rt_untwist_c", c, e_vec);
    check("rt_untwist_mode", 2'(mo), 2'd2);

    xfer("ut_ones", MODE_UNTWIST, splat(1), '0, c, mo);
`ifdef NEGA_PP_NINV_FOLD_EN
    check("ut_ones_c0", CW'(c[0 +: W]), CW'(211));
    check("ut_ones_c1", CW'(c[W +: W]), CW'(130));
`else
    check("ut_ones_c0", CW'(c[0 +: W]), CW'(1));
    check("ut_ones_c1", CW'(c[W +: W]), CW'(76));
`endif
    xfer("pass_rand", MODE_PASS, (r = rand_vec()), '0, c, mo);
    check("pass_rand_c", c, r);
    @(posedge clk); #1;

    // Back-pressure: three TWIST vectors, sink blocked for four cycles.
    exp_q.delete(); stall_prev = 1'b0;
    for (int i = 0; i < 3; i++) bp_vec[i] = rand_vec();
    idx = 0; n_before = n_out;
    for (int cyc = 0; cyc < 20 && (idx < 3 || exp_q.size() > 0); cyc++) begin
      run_cycle(idx < 3, MODE_TWIST, bp_vec[idx % 3], '0, cyc >= 4, acc);
      if (acc) idx++;
      if (cyc == 3) begin
        check("bp_accepts", idx, 2);
        check("bp_in_ready_low", in_ready, 1'b0);
      end
    end
    check("bp_outputs", n_out - n_before, 3);
    check("bp_sb_empty", exp_q.size(), 0);

    // Random traffic: fresh data every cycle, random valid and sink readiness.
    for (int cyc = 0; cyc < 400; cyc++)
      run_cycle($urandom_range(3) != 0, 2'($urandom_range(3)), rand_vec(), rand_vec(),
                $urandom_range(3) != 0, acc);
    for (int cyc = 0; cyc < 10; cyc++) run_cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
    check("rand_sb_empty", exp_q.size(), 0);

    // Reset with two vectors in flight.
    stall_prev = 1'b0;
    run_cycle(1'b1, MODE_TWIST, rand_vec(), '0, 1'b0, acc);
    run_cycle(1'b1, MODE_PASS, rand_vec(), '0, 1'b0, acc);
    check("mid_out_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_c_out", c_out, '0);
    exp_q.delete(); stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_init("reinit");
    for (int cyc = 0; cyc < 4; cyc++) begin
      run_cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
      check("reinit_no_stale", out_valid, 1'b0);
    end
    xfer("post_twist", MODE_TWIST, splat(1), '0, c, mo);
    check("post_twist_c", c, pack(exp_tw));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
